// File: rtl/fir_out_requant.sv
// Output conditioning stage behind the FIR filter: rounds the wide Q28
// accumulator to a Q1.15 sample with saturation, decimates by DECIM, and
// buffers kept samples in a small FIFO so the consumer can stall freely.
// Saturation and drop events are counted for debug.
module fir_out_requant #(
  parameter int IN_W     = 43,
  parameter int IN_FRAC  = 28,
  parameter int OUT_W    = 17,
  parameter int OUT_FRAC = 15,
  parameter int DECIM    = 2,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [IN_W-1:0]     y_in,
  input  logic                       in_valid,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                sat_cnt,
  output logic [15:0]                drop_cnt,
  output logic                       overflow
);

  localparam int SH    = IN_FRAC - OUT_FRAC;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [PH_W-1:0]       PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic signed [IN_W:0]  RND      = {{IN_W{1'b0}}, 1'b1} << (SH - 1);
  localparam logic signed [IN_W:0]  SAT_MAX  = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0]  SAT_MIN  = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic [PH_W-1:0]          ph_q, ph_d;
  logic                     keep;
  logic signed [IN_W:0]     yExt, sumW, rW;
  logic                     satHi, satLo;
  logic signed [OUT_W-1:0]  sample;

  logic signed [OUT_W-1:0]  stageData_q;
  logic                     stageKeep_q;
  logic [15:0]              satCnt_q, dropCnt_q;
  logic                     overflow_q;

  logic signed [OUT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]         wPtr_q, rPtr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     full, push, pop, drop;

  // Round half toward +inf at IN_W+1 bits (cannot wrap), then clamp to OUT_W.
  always_comb begin
    yExt   = {y_in[IN_W-1], y_in};
    sumW   = yExt + RND;
    rW     = sumW >>> SH;
    satHi  = rW > SAT_MAX;
    satLo  = rW < SAT_MIN;
    sample = rW[OUT_W-1:0];
    if (satHi) begin
      sample = SAT_MAX[OUT_W-1:0];
    end else if (satLo) begin
      sample = SAT_MIN[OUT_W-1:0];
    end
  end

  // Decimation phase: keep a sample only at phase zero, advance on every valid.
  always_comb begin
    keep = in_valid && (ph_q == '0);
    ph_d = ph_q;
    if (in_valid) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end
  end

  // FIFO handshake: a push into a full FIFO succeeds only if the head leaves.
  always_comb begin
    full      = (count_q == CNT_FULL);
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    push      = stageKeep_q && (!full || pop);
    drop      = stageKeep_q && full && !pop;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Phase counter, stage register and saturation counter update on the sampling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q        <= '0;
      stageData_q <= '0;
      stageKeep_q <= 1'b0;
      satCnt_q    <= '0;
    end else begin
      ph_q        <= ph_d;
      stageData_q <= sample;
      stageKeep_q <= keep;
      if (keep && (satHi || satLo) && (satCnt_q != 16'hFFFF)) begin
        satCnt_q <= satCnt_q + 16'd1;
      end
    end
  end

  // Circular buffer storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wPtr_q  <= '0;
      rPtr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wPtr_q] <= stageData_q;
        wPtr_q        <= wPtr_q + 1'b1;
      end
      if (pop) begin
        rPtr_q <= rPtr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Drop counter and sticky overflow update on the push edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      dropCnt_q  <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (dropCnt_q != 16'hFFFF) begin
        dropCnt_q <= dropCnt_q + 16'd1;
      end
    end
  end

  assign out_data   = mem_q[rPtr_q];
  assign fifo_level = count_q;
  assign sat_cnt    = satCnt_q;
  assign drop_cnt   = dropCnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: one instance with DECIM=1 and one with
// DECIM=2 share all inputs; each scenario checks the instance it targets.
module tb_fir_out_requant;

  logic               clk = 1'b0;
  logic               reset;
  logic               inValid;
  logic               outReady;
  logic signed [42:0] yIn;

  logic signed [16:0] outData1, outData2;
  logic               outValid1, outValid2;
  logic [2:0]         level1, level2;
  logic [15:0]        sat1, sat2, drop1, drop2;
  logic               ovf1, ovf2;

  int total = 0;
  int bad   = 0;

  fir_out_requant #(.DECIM(1)) dut1 (
    .clk(clk), .reset(reset), .y_in(yIn), .in_valid(inValid),
    .out_data(outData1), .out_valid(outValid1), .out_ready(outReady),
    .fifo_level(level1), .sat_cnt(sat1), .drop_cnt(drop1), .overflow(ovf1)
  );

  fir_out_requant #(.DECIM(2)) dut2 (
    .clk(clk), .reset(reset), .y_in(yIn), .in_valid(inValid),
    .out_data(outData2), .out_valid(outValid2), .out_ready(outReady),
    .fifo_level(level2), .sat_cnt(sat2), .drop_cnt(drop2), .overflow(ovf2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input longint y, input logic v);
    yIn     = 43'(y);
    inValid = v;
    tick();
  endtask

  task automatic doReset();
    reset   = 1'b1;
    inValid = 1'b0;
    tick();
    reset   = 1'b0;
  endtask

  task automatic sendOne(input longint y, input int expected, input string tag);
    applyStimulus(y, 1'b1);
    inValid = 1'b0;
    checkOutput({tag, "_notyet"}, int'(outValid1), 0);
    tick();
    checkOutput({tag, "_valid"}, int'(outValid1), 1);
    checkOutput({tag, "_data"}, int'(outData1), expected);
    tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_v1"}, int'(outValid1), 0);
    checkOutput({tag, "_d1"}, int'(outData1), 0);
    checkOutput({tag, "_lvl1"}, int'(level1), 0);
    checkOutput({tag, "_sat1"}, int'(sat1), 0);
    checkOutput({tag, "_drop1"}, int'(drop1), 0);
    checkOutput({tag, "_ovf1"}, int'(ovf1), 0);
    checkOutput({tag, "_v2"}, int'(outValid2), 0);
    checkOutput({tag, "_d2"}, int'(outData2), 0);
    checkOutput({tag, "_lvl2"}, int'(level2), 0);
    checkOutput({tag, "_sat2"}, int'(sat2), 0);
  endtask

  task automatic runDecim(input bit gap, input string tag);
    int got[$];
    doReset();
    outReady = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(longint'(k) * 8192, 1'b1);
      if (outValid2) got.push_back(int'(outData2));
      if (gap && k == 2) begin
        applyStimulus(0, 1'b0);
        if (outValid2) got.push_back(int'(outData2));
      end
    end
    inValid = 1'b0;
    repeat (4) begin
      tick();
      if (outValid2) got.push_back(int'(outData2));
    end
    checkOutput({tag, "_count"}, got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, "_val"}, (i < got.size()) ? got[i] : -999, 2 * i + 1);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drainExp[4];

    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    yIn      = '0;
    tick();
    reset = 1'b0;
    checkAllZero("reset");

    // Scaling and rounding, one sample at a time
    outReady = 1'b1;
    sendOne(longint'(1) << 28, 32768, "scale_q28");
    sendOne(longint'(1) << 27, 16384, "scale_half");
    sendOne(4096, 1, "rnd_up");
    sendOne(4095, 0, "rnd_down");
    sendOne(-4096, 0, "rnd_neg_half");
    sendOne(-4097, -1, "rnd_neg");
    checkOutput("scale_sat", int'(sat1), 0);

    // Saturation
    doReset();
    outReady = 1'b1;
    sendOne(longint'(1) << 30, 65535, "sat_pos");
    sendOne(-(longint'(1) << 30), -65536, "sat_neg");
    sendOne((longint'(1) << 29) - 1, 65535, "sat_round");
    checkOutput("sat_count", int'(sat1), 3);

    // Decimation by two, continuous and with a gap
    runDecim(1'b0, "decim");
    runDecim(1'b1, "decim_gap");

    // Full FIFO with drops
    doReset();
    outReady = 1'b0;
    for (int k = 1; k <= 6; k++) applyStimulus(longint'(k) * 8192, 1'b1);
    applyStimulus(0, 1'b0);
    checkOutput("full_level", int'(level1), 4);
    checkOutput("full_drop", int'(drop1), 2);
    checkOutput("full_ovf", int'(ovf1), 1);
    outReady = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("drain_valid", int'(outValid1), 1);
      checkOutput("drain_data", int'(outData1), k);
      tick();
    end
    checkOutput("drain_empty", int'(outValid1), 0);
    checkOutput("drain_level", int'(level1), 0);

    // Simultaneous push and pop while full
    outReady = 1'b0;
    for (int k = 1; k <= 4; k++) applyStimulus(longint'(k) * 8192, 1'b1);
    applyStimulus(7 * 8192, 1'b1);
    checkOutput("pp_prefull", int'(level1), 4);
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkOutput("pp_level", int'(level1), 4);
    checkOutput("pp_drop", int'(drop1), 2);
    drainExp = '{2, 3, 4, 7};
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("pp_order", int'(outData1), drainExp[i]);
      tick();
    end
    checkOutput("pp_empty", int'(outValid1), 0);

    // Reset in the middle of operation
    doReset();
    outReady = 1'b0;
    applyStimulus(longint'(1) << 30, 1'b1);
    applyStimulus(-(longint'(1) << 30), 1'b1);
    applyStimulus(3 * 8192, 1'b1);
    applyStimulus(0, 1'b1);
    checkOutput("mid_level", int'(level1), 3);
    checkOutput("mid_sat", int'(sat1), 2);
    reset   = 1'b1;
    yIn     = 43'(5 * 8192);
    inValid = 1'b1;
    tick();
    reset   = 1'b0;
    inValid = 1'b0;
    checkAllZero("midrst");
    tick();
    checkOutput("midrst_stage", int'(outValid1), 0);
    applyStimulus(5 * 8192, 1'b1);
    inValid = 1'b0;
    checkOutput("post_notyet", int'(outValid2), 0);
    tick();
    checkOutput("post_valid2", int'(outValid2), 1);
    checkOutput("post_data2", int'(outData2), 5);
    checkOutput("post_data1", int'(outData1), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output conditioning stage directly downstream of the FIR filter. Takes the filter's wide signed accumulator result (Q28 scaling), rounds and saturates it to a 17-bit Q1.15 sample, and decimates by a fixed factor. It buffers kept samples in a 4-entry FIFO behind a valid/ready interface, so the FFT block or a file-dump consumer can stall without disturbing the free-running filter. Saturation and drop events are counted for debug.

## Interface
- IN_W, 43, width of the signed filter result (`y_in`).
- IN_FRAC, 28, fractional bits of `y_in`.
- OUT_W, 17, width of the signed output sample.
- OUT_FRAC, 15, fractional bits of the output. Right shift `SH = IN_FRAC - OUT_FRAC = 13`; `SH >= 1` is required.
- DECIM, 2, decimation factor. Range 1..16; 1 keeps every sample.
- DEPTH, 4, FIFO entries (power of two).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock shared with the FIR filter.
- reset  in  1  synchronous, active-high; clears all state.
- y_in  in  IN_W  signed filter result.
- in_valid  in  1  `y_in` is a new sample this cycle. No back-pressure upstream.
- out_data  out  OUT_W  signed sample at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts `out_data` this cycle.
- fifo_level  out  3  entries held (0..4).
- sat_cnt  out  16  kept samples that saturated; sticks at 0xFFFF.
- drop_cnt  out  16  kept samples lost to a full FIFO; sticks at 0xFFFF.
- overflow  out  1  sticky; set on the first drop, cleared only by reset.

## Operation
- **Decimation phase counter** `ph` (0..DECIM-1):
  - Advances on each `in_valid` and wraps DECIM-1 -> 0.
  - A sample is *kept* only when `in_valid` is high and `ph == 0`.
  - The first valid sample after reset is kept.
- **Rounding**: `r = (y_in + 2^(SH-1)) >>> SH`.
  - Arithmetic shift; round half toward +inf.
  - The addition is done at IN_W+1 bits, so it cannot wrap.
- **Saturation**: if `r > 2^(OUT_W-1)-1`, output 65535; if `r < -2^(OUT_W-1)`, output -65536. Otherwise output `r[OUT_W-1:0]`.
  - `sat_cnt` increments only for kept samples that saturate.
- **Stage register**: holds the rounded/saturated value plus a `keep` flag. It is loaded every cycle; `keep` is 0 when the sample was not kept.
- **FIFO**: circular buffer with 2-bit read and write pointers plus a 3-bit count.
  - Push occurs when the stage `keep` flag is 1 and there is space.
  - Pop occurs when `out_valid && out_ready`.
  - Push when full with a simultaneous pop: both happen, level unchanged, no drop.
  - Push when full with no pop: sample discarded, `drop_cnt`+1, `overflow`=1, FIFO contents unchanged.
  - Pop when empty: ignored; `out_ready` is don't-care when `out_valid`=0.
- `out_data` is the entry at the read pointer. It is stable while `out_valid && !out_ready`.
- `out_data` must not change while `out_valid`=0 → 1 transitions are in progress, except for the newly written head.

## Timing
- **Reset values** (on the first rising edge with `reset`=1): `out_valid`=0, `out_data`=0, `fifo_level`=0, `sat_cnt`=0, `drop_cnt`=0, `overflow`=0, `ph`=0, stage `keep`=0, pointers 0.
  - A reset mid-operation discards buffered and staged samples that same edge.
  - `in_valid` during reset is ignored.
- **Latency**: a kept sample sampled at edge E is in the stage register after E and written to the FIFO at E+1.
  - `out_valid` rises after E+1 if the FIFO was empty.
  - That gives 2 clocks from sampling edge to visible output.
- **Throughput**: one push and one pop per cycle. With `out_ready` held high and DECIM=1, `fifo_level` never exceeds 1.
- **Counter update timing**: `sat_cnt` updates on the stage-load edge (E). `drop_cnt` and `overflow` update on the push edge (E+1).
- `fifo_level` is registered and reflects pushes and pops of the previous edge.

## Test plan
- **Scaling/rounding**, DECIM=1, `out_ready`=1:
  - `y_in` = 2^28 -> 32768
  - 2^27 -> 16384
  - 4096 -> 1
  - 4095 -> 0
  - -4096 -> 0
  - -4097 -> -1
  - Each appears 2 cycles after its sampling edge; `sat_cnt`=0.
- **Saturation**, DECIM=1:
  - `y_in` = 2^30 -> 65535.
  - `y_in` = -2^30 -> -65536.
  - `y_in` = 2^29-1 -> 65536 after rounding, then clamps to 65535.
  - `sat_cnt`=3 at the end.
- **Decimation**, DECIM=2, `out_ready`=1:
  - Input `y_in` = k·8192 for k=1..6, `in_valid` continuous.
  - Outputs are 1, 3, 5 only.
  - With one `in_valid`=0 gap inserted after k=2, the outputs are still 1, 3, 5.
- **Full FIFO / drop**, DECIM=1:
  - `out_ready`=0, feed values 1..6 (scaled).
  - `fifo_level`=4, `drop_cnt`=2, `overflow`=1.
  - Then `out_ready`=1: drains 1, 2, 3, 4 on consecutive cycles; `out_valid` falls after the 4th.
- **Simultaneous push/pop at full**:
  - FIFO holds 4 entries; assert `out_ready` on the same cycle a kept sample arrives.
  - `fifo_level` stays 4 and `drop_cnt` is unchanged.
  - Drain order: the old entries, then the new one.
- **Reset mid-operation**:
  - With 3 entries buffered and `sat_cnt`=2, assert `reset` for 1 cycle.
  - Next cycle: all outputs are zero.
  - The next kept input is sample phase 0 and appears 2 cycles later.
